// File: rtl/tweet_pkg.sv
// Shared constants and state encodings for the tweet message recorder/replayer.
package tweet_pkg;

    localparam int CLKS_PER_BIT_9600_50M = 5208;
    localparam logic [7:0] BS_CODE_DEFAULT = 8'h08;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_STORE
    } rx_state_e;

    typedef enum logic [1:0] {
        PL_IDLE,
        PL_LOAD,
        PL_SEND
    } play_state_e;

    // Counter width that stays legal (>= 1 bit) even for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tweet_uart_tx.sv
// UART frame serialiser: one start bit, DATA_BITS data bits LSB first, one stop bit.
module tweet_uart_tx
    import tweet_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_50M
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = cnt_width(DATA_BITS + 2);
    localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_BIT   = BW'(DATA_BITS + 1);

    logic [CW-1:0]      cnt_q;
    logic [BW-1:0]      bit_q;
    logic [DATA_BITS:0] shift_q;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    // Stop bit rides at the top of the shifter behind the data.
                    busy_q  <= 1'b1;
                    tx_q    <= 1'b0;
                    shift_q <= {1'b1, data_i};
                    cnt_q   <= BIT_RELOAD;
                    bit_q   <= '0;
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end else if (bit_q == STOP_BIT) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                tx_q   <= 1'b1;
            end else begin
                tx_q    <= shift_q[0];
                shift_q <= {1'b1, shift_q[DATA_BITS:1]};
                bit_q   <= bit_q + BW'(1);
                cnt_q   <= BIT_RELOAD;
            end
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/tweet_buffer.sv
// UART message recorder/replayer: captures characters into a RAM (with backspace
// and clear) and replays the stored message as UART frames on a play pulse.
module tweet_buffer
    import tweet_pkg::*;
#(
    parameter int                   DATA_BITS    = 8,
    parameter int                   DEPTH        = 160,
    parameter int                   CLKS_PER_BIT = CLKS_PER_BIT_9600_50M,
    parameter logic [DATA_BITS-1:0] BS_CODE      = DATA_BITS'(BS_CODE_DEFAULT),
    parameter int                   ECHO         = 1
) (
    input  logic                         sysclk,
    input  logic                         reset_n,
    input  logic                         active,
    input  logic                         rx,
    input  logic                         play,
    input  logic                         clear,
    output logic                         tx,
    output logic                         rx_valid,
    output logic [DATA_BITS-1:0]         rx_data,
    output logic                         frame_err,
    output logic                         overflow,
    output logic                         busy_tx,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW  = cnt_width(CLKS_PER_BIT);
    localparam int DBW = cnt_width(DATA_BITS);
    localparam int AW  = $clog2(DEPTH);
    localparam int NW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [DBW-1:0] LAST_DATA   = DBW'(DATA_BITS - 1);
    localparam logic [NW-1:0]  FULL        = NW'(DEPTH);

    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_e            rx_state_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [DBW-1:0]       rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_valid_q, frame_err_q, overflow_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [NW-1:0]        count_q;

    play_state_e          pl_state_q;
    logic [AW-1:0]        idx_q;
    logic                 busy_q, done_q, tx_start_q;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] ram_rd_q;
    logic [AW-1:0]        ram_addr;
    logic                 ram_we, ram_re;

    logic tx_ser, tx_busy, tx_done;
    logic play_start, is_bs;

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign is_bs      = (rx_shift_q == BS_CODE);
    assign play_start = (pl_state_q == PL_IDLE) && play && !clear && !busy_q && active
                        && (rx_state_q == RX_IDLE) && (count_q != '0);
    assign ram_we     = (rx_state_q == RX_STORE) && !clear && !is_bs && (count_q != FULL);
    assign ram_re     = (pl_state_q == PL_LOAD);
    assign ram_addr   = ram_we ? count_q[AW-1:0] : idx_q;

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            rx_data_q   <= '0;
            count_q     <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (active && !busy_q && !play_start && rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= HALF_RELOAD;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end else if (!rx_sync_q) begin
                        rx_state_q <= RX_DATA;
                        rx_cnt_q   <= BIT_RELOAD;
                        rx_bit_q   <= '0;
                    end else begin
                        frame_err_q <= 1'b1;
                        rx_state_q  <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end else begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_cnt_q   <= BIT_RELOAD;
                        if (rx_bit_q == LAST_DATA) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + DBW'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end else if (rx_sync_q) begin
                        rx_state_q <= RX_STORE;
                    end else begin
                        frame_err_q <= 1'b1;
                        rx_state_q  <= RX_IDLE;
                    end
                end
                RX_STORE: begin
                    rx_state_q <= RX_IDLE;
                    if (!clear) begin
                        if (is_bs) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_shift_q;
                            if (count_q != '0) count_q <= count_q - NW'(1);
                        end else if (count_q == FULL) begin
                            overflow_q <= 1'b1;
                        end else begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_shift_q;
                            count_q    <= count_q + NW'(1);
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
            // Clear overrides any STORE update above; playback locks it out.
            if (clear && !busy_q) count_q <= '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (ram_we) begin
            mem[ram_addr] <= rx_shift_q;
        end else if (ram_re) begin
            ram_rd_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            pl_state_q <= PL_IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            case (pl_state_q)
                PL_IDLE: begin
                    busy_q <= 1'b0;
                    if (play_start) begin
                        pl_state_q <= PL_LOAD;
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                    end else if (play && !busy_q && (clear || count_q == '0)) begin
                        done_q <= 1'b1;
                    end
                end
                PL_LOAD: begin
                    pl_state_q <= PL_SEND;
                    tx_start_q <= 1'b1;
                end
                PL_SEND: begin
                    if (tx_done) begin
                        if (active && (NW'(idx_q) + NW'(1) < count_q)) begin
                            pl_state_q <= PL_LOAD;
                            idx_q      <= idx_q + AW'(1);
                        end else begin
                            // busy_q stays high through this done cycle.
                            done_q     <= 1'b1;
                            pl_state_q <= PL_IDLE;
                        end
                    end
                end
                default: pl_state_q <= PL_IDLE;
            endcase
        end
    end

    tweet_uart_tx #(
        .DATA_BITS   (DATA_BITS),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i  (sysclk),
        .rst_ni (reset_n),
        .start_i(tx_start_q),
        .data_i (ram_rd_q),
        .tx_o   (tx_ser),
        .busy_o (tx_busy),
        .done_o (tx_done)
    );

    assign tx        = tx_busy ? tx_ser : (busy_q ? 1'b1 : ((ECHO != 0) ? rx_sync_q : 1'b1));
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign busy_tx   = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_tweet_buffer.sv
// Directed bench for tweet_buffer at DEPTH=4, CLKS_PER_BIT=16.
module tb_tweet_buffer;
    import tweet_pkg::*;

    localparam int CPB = 16;
    localparam int DEP = 4;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       active = 1'b1;
    logic       rx = 1'b1;
    logic       play = 1'b0;
    logic       clear = 1'b0;
    logic       tx;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overflow;
    logic       busy_tx;
    logic       done;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0, fe_cnt = 0, ov_cnt = 0, dn_cnt = 0;

    tweet_buffer #(
        .DATA_BITS   (8),
        .DEPTH       (DEP),
        .CLKS_PER_BIT(CPB),
        .BS_CODE     (8'h08),
        .ECHO        (1)
    ) dut (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .active   (active),
        .rx       (rx),
        .play     (play),
        .clear    (clear),
        .tx       (tx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .frame_err(frame_err),
        .overflow (overflow),
        .busy_tx  (busy_tx),
        .done     (done),
        .count    (count)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (rx_valid)  rv_cnt <= rv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overflow)  ov_cnt <= ov_cnt + 1;
        if (done)      dn_cnt <= dn_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        $display("send char 0x%02h stop=%0b", b, stop_bit);
        @(negedge sysclk) rx = 1'b0;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge sysclk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge sysclk);
        rx = 1'b1;
        repeat (8) @(negedge sysclk);
    endtask

    task automatic pulse_play();
        @(negedge sysclk) play = 1'b1;
        @(negedge sysclk) play = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge sysclk) clear = 1'b1;
        @(negedge sysclk) clear = 1'b0;
        @(negedge sysclk);
    endtask

    // Decodes one frame from tx while playback runs; ok=0 on timeout.
    task automatic capture_frame(output logic [7:0] b, output bit ok, output int busy_low);
        int t;
        b = 8'h00;
        ok = 1'b0;
        busy_low = 0;
        t = 0;
        while (!(tx === 1'b0 && busy_tx === 1'b1) && t < 200) begin
            @(negedge sysclk);
            t++;
        end
        if (t >= 200) return;
        repeat (CPB / 2) @(negedge sysclk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge sysclk);
            b[i] = tx;
            if (busy_tx !== 1'b1) busy_low++;
        end
        repeat (CPB) @(negedge sysclk);
        if (tx !== 1'b1) return;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge sysclk);
        reset_n = 1'b1;
        @(negedge sysclk);
        $display("reset released");
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulses: got %b%b%b want 000", rx_valid, frame_err, overflow);
        end
        n_cmp++; if (busy_tx !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy_tx, done);
        end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %02h want 00", rx_data); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    endtask

    task automatic test_receive_hi();
        int rv0 = rv_cnt, fe0 = fe_cnt;
        uart_send(8'h48, 1'b1);
        n_cmp++; if (rx_data !== 8'h48) begin n_bad++; $display("FAIL hi_first_data: got %02h want 48", rx_data); end
        uart_send(8'h49, 1'b1);
        n_cmp++; if (rv_cnt - rv0 != 2) begin n_bad++; $display("FAIL hi_rx_valid: got %0d want 2", rv_cnt - rv0); end
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL hi_count: got %0d want 2", count); end
        n_cmp++; if (rx_data !== 8'h49) begin n_bad++; $display("FAIL hi_rx_data: got %02h want 49", rx_data); end
        n_cmp++; if (fe_cnt != fe0) begin n_bad++; $display("FAIL hi_frame_err: got %0d want 0", fe_cnt - fe0); end
        pulse_clear();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL hi_clear_idle: got %0d want 0", count); end
    endtask

    task automatic test_backspace_play();
        logic [7:0] b;
        bit ok;
        int bl;
        int dn0;
        uart_send(8'h41, 1'b1);
        uart_send(8'h42, 1'b1);
        uart_send(8'h43, 1'b1);
        uart_send(8'h08, 1'b1);
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL bs_count: got %0d want 2", count); end
        n_cmp++; if (rx_data !== 8'h08) begin n_bad++; $display("FAIL bs_rx_data: got %02h want 08", rx_data); end
        dn0 = dn_cnt;
        pulse_play();
        $display("play with count=2");
        capture_frame(b, ok, bl);
        n_cmp++; if (!ok || b !== 8'h41) begin n_bad++; $display("FAIL play_frame0: got %02h ok=%0b want 41 ok=1", b, ok); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL play_busy0: got %0d low samples want 0", bl); end
        capture_frame(b, ok, bl);
        n_cmp++; if (!ok || b !== 8'h42) begin n_bad++; $display("FAIL play_frame1: got %02h ok=%0b want 42 ok=1", b, ok); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL play_busy1: got %0d low samples want 0", bl); end
        begin
            int t = 0;
            while (done !== 1'b1 && t < 40) begin @(negedge sysclk); t++; end
            n_cmp++; if (t >= 40) begin n_bad++; $display("FAIL play_done: got no done want done pulse"); end
            n_cmp++; if (busy_tx !== 1'b1) begin n_bad++; $display("FAIL play_busy_at_done: got %b want 1", busy_tx); end
        end
        @(negedge sysclk);
        n_cmp++; if (busy_tx !== 1'b0 || tx !== 1'b1) begin
            n_bad++; $display("FAIL play_after_done: got busy=%b tx=%b want busy=0 tx=1", busy_tx, tx);
        end
        n_cmp++; if (dn_cnt - dn0 != 1) begin n_bad++; $display("FAIL play_done_count: got %0d want 1", dn_cnt - dn0); end
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL play_count_kept: got %0d want 2", count); end
    endtask

    task automatic test_overflow();
        int rv0, ov0;
        pulse_clear();
        rv0 = rv_cnt;
        ov0 = ov_cnt;
        for (int i = 0; i < 4; i++) uart_send(8'h31 + 8'(i), 1'b1);
        n_cmp++; if (ov_cnt != ov0) begin n_bad++; $display("FAIL ovf_early: got %0d want 0", ov_cnt - ov0); end
        uart_send(8'h35, 1'b1);
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", count); end
        n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL ovf_pulse: got %0d want 1", ov_cnt - ov0); end
        n_cmp++; if (rv_cnt - rv0 != 4) begin n_bad++; $display("FAIL ovf_rx_valid: got %0d want 4", rv_cnt - rv0); end
        n_cmp++; if (rx_data !== 8'h34) begin n_bad++; $display("FAIL ovf_rx_data: got %02h want 34", rx_data); end
        pulse_clear();
        rv0 = rv_cnt;
        uart_send(8'h08, 1'b1);
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL bs_empty_count: got %0d want 0", count); end
        n_cmp++; if (rv_cnt - rv0 != 1) begin n_bad++; $display("FAIL bs_empty_valid: got %0d want 1", rv_cnt - rv0); end
    endtask

    task automatic test_frame_errors();
        int rv0, fe0;
        uart_send(8'h58, 1'b1);
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        uart_send(8'h55, 1'b0);
        n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL stop_err: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (count !== 3'd1 || rv_cnt != rv0) begin
            n_bad++; $display("FAIL stop_err_count: got count=%0d valid=%0d want 1 and 0", count, rv_cnt - rv0);
        end
        fe0 = fe_cnt;
        $display("start glitch 4 cycles");
        @(negedge sysclk) rx = 1'b0;
        repeat (4) @(negedge sysclk);
        rx = 1'b1;
        repeat (30) @(negedge sysclk);
        n_cmp++; if (fe_cnt - fe0 != 1) begin n_bad++; $display("FAIL glitch_err: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL glitch_count: got %0d want 1", count); end
    endtask

    task automatic test_active_low();
        int rv0 = rv_cnt;
        active = 1'b0;
        uart_send(8'h5A, 1'b1);
        active = 1'b1;
        n_cmp++; if (rv_cnt != rv0 || count !== 3'd1) begin
            n_bad++; $display("FAIL inactive_rx: got valid=%0d count=%0d want 0 and 1", rv_cnt - rv0, count);
        end
    endtask

    task automatic test_clear_in_store();
        int rv0 = rv_cnt;
        bit seen = 1'b0;
        fork
            uart_send(8'h59, 1'b1);
            begin
                int t = 0;
                while (!(dut.rx_state_q == RX_STORE) && t < 400) begin @(negedge sysclk); t++; end
                if (t < 400) begin
                    seen = 1'b1;
                    clear = 1'b1;
                    @(negedge sysclk) clear = 1'b0;
                end
            end
        join
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL store_seen: got no STORE want STORE"); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL store_clear_count: got %0d want 0", count); end
        n_cmp++; if (rv_cnt != rv0) begin n_bad++; $display("FAIL store_clear_valid: got %0d want 0", rv_cnt - rv0); end
        @(negedge sysclk) play = 1'b1;
        @(negedge sysclk) play = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy_tx !== 1'b0) begin
            n_bad++; $display("FAIL empty_play: got done=%b busy=%b want 1 0", done, busy_tx);
        end
        begin
            int busy_seen = 0;
            repeat (5) begin @(negedge sysclk); if (busy_tx !== 1'b0) busy_seen++; end
            n_cmp++; if (busy_seen != 0) begin n_bad++; $display("FAIL empty_play_busy: got %0d want 0", busy_seen); end
        end
    endtask

    task automatic test_reset_mid_play();
        int t = 0;
        uart_send(8'h48, 1'b1);
        uart_send(8'h49, 1'b1);
        pulse_play();
        while (!(tx === 1'b0 && busy_tx === 1'b1) && t < 200) begin @(negedge sysclk); t++; end
        n_cmp++; if (t >= 200) begin n_bad++; $display("FAIL rst_play_start: got no frame want frame"); end
        repeat (20) @(negedge sysclk);
        $display("reset pulse mid-playback");
        reset_n = 1'b0;
        @(negedge sysclk) reset_n = 1'b1;
        n_cmp++; if (tx !== 1'b1 || busy_tx !== 1'b0 || count !== 3'd0) begin
            n_bad++; $display("FAIL rst_mid: got tx=%b busy=%b count=%0d want 1 0 0", tx, busy_tx, count);
        end
        repeat (3) @(negedge sysclk);
        @(negedge sysclk) play = 1'b1;
        @(negedge sysclk) play = 1'b0;
        n_cmp++; if (done !== 1'b1 || busy_tx !== 1'b0) begin
            n_bad++; $display("FAIL rst_then_play: got done=%b busy=%b want 1 0", done, busy_tx);
        end
    endtask

    initial begin
        test_reset();
        test_receive_hi();
        test_backspace_play();
        test_overflow();
        test_frame_errors();
        test_active_low();
        test_clear_in_store();
        test_reset_mid_play();
        repeat (4) @(negedge sysclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
